// File: rtl/sram_pkg.sv
// Shared types and default widths for the SRAM write controller.
package sram_pkg;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 20;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } wr_state_e;

endpackage

// File: rtl/sram_wr_fifo.sv
// Synchronous FIFO queuing write requests (used only when SRAM_WR_BUF_EN is defined).
// Zero-latency show-ahead read; push ignored when full, pop ignored when empty; DEPTH must be a power of 2.
module sram_wr_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_pop_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_pop_dat = r_mem[r_rptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

  // Simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_write_ctrl.sv
// Async-SRAM write sequencer: SETUP, PULSE_CYC-cycle WE_N pulse, HOLD; Wr_done 2+PULSE_CYC cycles after accept.
// SRAM_WR_BUF_EN adds a 4-entry request FIFO (Wr_ready = not full); otherwise Wr_ready only in IDLE with Rd_busy low.
module sram_write_ctrl
  import sram_pkg::*;
#(
  parameter int N         = SRAM_DW,
  parameter int A         = SRAM_AW,
  parameter int PULSE_CYC = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Wr_valid,
  output logic         Wr_ready,
  input  logic [A-1:0] Wr_addr,
  input  logic [N-1:0] Wr_data,
  input  logic         Rd_busy,
  output logic         Wr_done,
  output logic         Busy,
  output logic         SRAM_CE_N,
  output logic         SRAM_WE_N,
  output logic [A-1:0] SRAM_ADDR,
  inout  wire  [N-1:0] Data
);

  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);

  wr_state_e    r_state;
  wr_state_e    w_next;
  logic [3:0]   r_cnt;
  logic [A-1:0] r_addr;
  logic [N-1:0] r_data;
  logic         r_ce_n;
  logic         r_we_n;
  logic         r_drv;
  logic         r_done;
  logic         r_live;
  logic         w_avail;
  logic         w_take;
  logic [A-1:0] w_req_addr;
  logic [N-1:0] w_req_data;

`ifdef SRAM_WR_BUF_EN
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic         w_push;
  logic         w_pop;
  logic [A+N-1:0] w_fifo_dat;

  // An empty FIFO is bypassed so a lone request still reaches SETUP one cycle after accept.
  assign Wr_ready   = r_live && !w_fifo_full;
  assign w_avail    = !w_fifo_empty || (Wr_valid && Wr_ready);
  assign {w_req_addr, w_req_data} = w_fifo_empty ? {Wr_addr, Wr_data} : w_fifo_dat;
  assign w_pop      = w_take && !w_fifo_empty;
  assign w_push     = Wr_valid && Wr_ready && !(w_take && w_fifo_empty);

  sram_wr_fifo #(
    .W     (A + N),
    .DEPTH (4)
  ) u_fifo (
    .i_clk      (Clk),
    .i_rst_n    (Reset_n),
    .i_push     (w_push),
    .i_push_dat ({Wr_addr, Wr_data}),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );
`else
  assign Wr_ready   = r_live && (r_state == IDLE) && !Rd_busy;
  assign w_avail    = Wr_valid && Wr_ready;
  assign w_req_addr = Wr_addr;
  assign w_req_data = Wr_data;
`endif

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_avail && !Rd_busy) begin
          w_take = 1'b1;
          w_next = SETUP;
        end
      end
      SETUP: w_next = PULSE;
      PULSE: begin
        if (r_cnt == 4'd0) w_next = HOLD;
      end
      HOLD: begin
        if (w_avail && !Rd_busy) begin
          w_take = 1'b1;
          w_next = SETUP;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they switch cleanly with the state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ce_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_drv   <= 1'b0;
      r_done  <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_next;
      if (w_take) begin
        r_addr <= w_req_addr;
        r_data <= w_req_data;
      end
      if (r_state == SETUP)
        r_cnt <= PULSE_LD;
      else if (r_state == PULSE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      r_ce_n <= (w_next == IDLE);
      r_we_n <= (w_next != PULSE);
      r_drv  <= (w_next != IDLE);
      r_done <= (w_next == HOLD);
    end
  end

  assign Busy      = (r_state != IDLE);
  assign Wr_done   = r_done;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_ADDR = r_addr;
  assign Data      = r_drv ? r_data : {N{1'bz}};

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Directed bench for sram_write_ctrl with a completion scoreboard; the bench drives a fixed pattern on Data whenever CE_N is high.
module tb_sram_write_ctrl;

  localparam int N  = 16;
  localparam int A  = 20;
  localparam int PC = 2;
  localparam logic [N-1:0] PAT = 16'hA5C3;

  logic         Clk      = 1'b0;
  logic         Reset_n  = 1'b0;
  logic         Wr_valid = 1'b0;
  logic         Rd_busy  = 1'b0;
  logic [A-1:0] Wr_addr  = '0;
  logic [N-1:0] Wr_data  = '0;
  logic         Wr_ready;
  logic         Wr_done;
  logic         Busy;
  logic         SRAM_CE_N;
  logic         SRAM_WE_N;
  logic [A-1:0] SRAM_ADDR;
  wire  [N-1:0] Data;

  assign Data = SRAM_CE_N ? PAT : {N{1'bz}};

  sram_write_ctrl #(.N(N), .A(A), .PULSE_CYC(PC)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Wr_valid  (Wr_valid),
    .Wr_ready  (Wr_ready),
    .Wr_addr   (Wr_addr),
    .Wr_data   (Wr_data),
    .Rd_busy   (Rd_busy),
    .Wr_done   (Wr_done),
    .Busy      (Busy),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_ADDR (SRAM_ADDR),
    .Data      (Data)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [A-1:0] addr;
    logic [N-1:0] dat;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_write(input logic [A-1:0] a, input logic [N-1:0] d, input int done_cyc);
    exp_t e;
    e.addr = a;
    e.dat  = d;
    e.cyc  = done_cyc;
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(negedge Clk);
  endtask

  // Completion monitor: every Wr_done must match the oldest expected write.
  always @(negedge Clk) begin
    exp_t e;
    if (Wr_done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", {31'b0, Wr_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_addr", SRAM_ADDR, e.addr);
        chk("done_data", Data, e.dat);
        chk("done_cycle", cyc, e.cyc);
      end
    end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
      e = sb.pop_front();
      chk("done_pulse", {31'b0, Wr_done}, 32'd1);
    end
  end

  initial begin
    int t;

    // Reset: outputs quiet and no acceptance even with a request present.
    Wr_valid = 1'b1;
    Wr_addr  = 20'h00001;
    Wr_data  = 16'h0001;
    repeat (3) nxt();
    #1;
    chk("rst_ce_n",  SRAM_CE_N, 1);
    chk("rst_we_n",  SRAM_WE_N, 1);
    chk("rst_addr",  SRAM_ADDR, 0);
    chk("rst_data",  Data, PAT);
    chk("rst_done",  Wr_done, 0);
    chk("rst_busy",  Busy, 0);
    chk("rst_ready", Wr_ready, 0);
    Wr_valid = 1'b0;
    nxt();
    Reset_n = 1'b1;
    #1 chk("ready_at_release", Wr_ready, 0);
    nxt();
    #1 chk("ready_after_edge", Wr_ready, 1);

    // Single write 0x00012 / 0xBEEF.
    nxt();
    t = cyc;
    Wr_valid = 1'b1;
    Wr_addr  = 20'h00012;
    Wr_data  = 16'hBEEF;
    #1 chk("w1_ready", Wr_ready, 1);
    expect_write(20'h00012, 16'hBEEF, t + 2 + PC);
    nxt();
    Wr_valid = 1'b0;
    chk("w1_setup_ce", SRAM_CE_N, 0);
    chk("w1_setup_we", SRAM_WE_N, 1);
    chk("w1_setup_data", Data, 16'hBEEF);
    chk("w1_setup_addr", SRAM_ADDR, 20'h00012);
    chk("w1_setup_busy", Busy, 1);
    nxt();
    chk("w1_pulse1_we", SRAM_WE_N, 0);
    chk("w1_pulse1_data", Data, 16'hBEEF);
    nxt();
    chk("w1_pulse2_we", SRAM_WE_N, 0);
    nxt();
    chk("w1_hold_we", SRAM_WE_N, 1);
    chk("w1_hold_ce", SRAM_CE_N, 0);
    nxt();
    chk("w1_idle_ce", SRAM_CE_N, 1);
    chk("w1_idle_busy", Busy, 0);
    chk("w1_idle_data", Data, PAT);

    // Rd_busy held 5 cycles with a pending request.
    nxt();
    t = cyc;
    Rd_busy  = 1'b1;
    Wr_valid = 1'b1;
    Wr_addr  = 20'h00345;
    Wr_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
`ifdef SRAM_WR_BUF_EN
      if (i > 0) Wr_valid = 1'b0;
      #1 chk("rb_ready", Wr_ready, 1);
`else
      #1 chk("rb_ready", Wr_ready, 0);
`endif
      chk("rb_ce", SRAM_CE_N, 1);
      chk("rb_data", Data, PAT);
      nxt();
    end
    Rd_busy = 1'b0;
`ifndef SRAM_WR_BUF_EN
    #1 chk("rb_ready_release", Wr_ready, 1);
`endif
    expect_write(20'h00345, 16'h1234, t + 5 + 2 + PC);
    nxt();
    Wr_valid = 1'b0;
    chk("rb_setup_ce", SRAM_CE_N, 0);
    repeat (5) nxt();

    // Two back-to-back requests.
    t = cyc;
    Wr_valid = 1'b1;
    Wr_addr  = 20'h0A001;
    Wr_data  = 16'h1111;
    #1 chk("b2b_ready_a", Wr_ready, 1);
    expect_write(20'h0A001, 16'h1111, t + 4);
    nxt();
    Wr_addr = 20'h0B002;
    Wr_data = 16'h2222;
`ifdef SRAM_WR_BUF_EN
    #1 chk("b2b_ready_b", Wr_ready, 1);
    expect_write(20'h0B002, 16'h2222, t + 8);
    nxt();
`else
    for (int i = 1; i < 5; i++) begin
      #1 chk("b2b_ready_wait", Wr_ready, 0);
      nxt();
    end
    #1 chk("b2b_ready_b", Wr_ready, 1);
    expect_write(20'h0B002, 16'h2222, t + 9);
    nxt();
`endif
    Wr_valid = 1'b0;
    repeat (8) nxt();

`ifdef SRAM_WR_BUF_EN
    // Fill the FIFO behind Rd_busy, then drain at one write per PC+2 cycles.
    t = cyc;
    Rd_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Wr_valid = 1'b1;
      Wr_addr  = 20'h10000 + 20'(i);
      Wr_data  = 16'hC000 + 16'(i);
      #1 chk("fill_ready", Wr_ready, (i < 4) ? 32'd1 : 32'd0);
      expect_write(20'h10000 + 20'(i), 16'hC000 + 16'(i), t + 9 + 4 * i);
      nxt();
    end
    Rd_busy = 1'b0;
    #1 chk("fill_ready_full", Wr_ready, 0);
    nxt();
    #1 chk("fill_ready_pop", Wr_ready, 1);
    nxt();
    Wr_valid = 1'b0;
    repeat (20) nxt();
`endif

    // Rd_busy raised mid-pulse must not disturb the write.
    t = cyc;
    Wr_valid = 1'b1;
    Wr_addr  = 20'h0ABCD;
    Wr_data  = 16'h5A5A;
    expect_write(20'h0ABCD, 16'h5A5A, t + 2 + PC);
    nxt();
    Wr_valid = 1'b0;
    nxt();
    Rd_busy = 1'b1;
    chk("rbp_we1", SRAM_WE_N, 0);
    nxt();
    chk("rbp_we2", SRAM_WE_N, 0);
    chk("rbp_addr", SRAM_ADDR, 20'h0ABCD);
    nxt();
    chk("rbp_hold_ce", SRAM_CE_N, 0);
    chk("rbp_hold_we", SRAM_WE_N, 1);
    nxt();
    chk("rbp_idle_busy", Busy, 0);
    Rd_busy = 1'b0;

    // Reset during the second pulse cycle aborts the write and drops queued work.
    nxt();
    Wr_valid = 1'b1;
    Wr_addr  = 20'h0DEAD;
    Wr_data  = 16'h7777;
    nxt();
`ifdef SRAM_WR_BUF_EN
    Wr_addr = 20'h0FACE;
    Wr_data = 16'h8888;
`else
    Wr_valid = 1'b0;
`endif
    nxt();
    Wr_valid = 1'b0;
    nxt();
    chk("ar_we_before", SRAM_WE_N, 0);
    Reset_n = 1'b0;
    #1;
    chk("ar_we",    SRAM_WE_N, 1);
    chk("ar_ce",    SRAM_CE_N, 1);
    chk("ar_data",  Data, PAT);
    chk("ar_busy",  Busy, 0);
    chk("ar_ready", Wr_ready, 0);
    nxt();
    nxt();
    Reset_n = 1'b1;
    nxt();
    for (int i = 0; i < 8; i++) begin
      chk("ar_quiet_ce", SRAM_CE_N, 1);
      nxt();
    end
    chk("ar_quiet_busy", Busy, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_write_ctrl.md
SRAM_WRITE_CTRL -- requirements
Module: sram_write_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the SRAM data width.
REQ-002 The block SHALL have parameter A, default 20, giving the SRAM address width.
REQ-003 The block SHALL have parameter PULSE_CYC, default 2, giving the WE_N low time in clocks; legal range 1..15.
REQ-004 The block SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port Wr_valid  input  1  write request present.
REQ-007 The block SHALL have port Wr_ready  output  1  request accepted when Wr_valid && Wr_ready at a rising edge.
REQ-008 The block SHALL have port Wr_addr  input  A  write address, sampled on accept.
REQ-009 The block SHALL have port Wr_data  input  N  write data, sampled on accept.
REQ-010 The block SHALL have port Rd_busy  input  1  read path owns the SRAM bus; blocks the start of a new write.
REQ-011 The block SHALL have port Wr_done  output  1  one-cycle pulse when a write completes.
REQ-012 The block SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-013 The block SHALL have port SRAM_CE_N  output  1  chip enable, active low.
REQ-014 The block SHALL have port SRAM_WE_N  output  1  write enable, active low.
REQ-015 The block SHALL have port SRAM_ADDR  output  A  registered write address.
REQ-016 The block SHALL have port Data  inout  N  shared SRAM data bus, driven only during a write.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, PULSE and HOLD.
REQ-018 IDLE->SETUP SHALL occur when a request is available and Rd_busy=0; otherwise the FSM stays in IDLE.
REQ-019 SETUP SHALL last 1 cycle with CE_N=0, WE_N=1, SRAM_ADDR/Data driven from registered buffers.
REQ-020 PULSE SHALL last exactly PULSE_CYC cycles with CE_N=0 and WE_N=0, counted by a 4-bit down-counter.
REQ-021 HOLD SHALL last 1 cycle with CE_N=0, WE_N=1, Data still driven, and Wr_done=1.
REQ-022 HOLD->SETUP SHALL occur directly when another request is available and Rd_busy=0; otherwise HOLD->IDLE.
REQ-023 Data SHALL be driven from the registered write buffer from SETUP through HOLD inclusive, and SHALL be all-Z in IDLE.
REQ-024 SRAM_ADDR and the write buffer SHALL hold constant from SETUP through HOLD of each write.
REQ-025 A Rd_busy assertion during SETUP/PULSE/HOLD SHALL NOT abort or stretch the write in progress.
REQ-026 With a request accepted at cycle 0 and the FSM in IDLE, SETUP SHALL be at cycle 1 and Wr_done at cycle 2+PULSE_CYC.
REQ-027 Writes SHALL complete in acceptance order, one Wr_done per accepted request.

Reset
REQ-028 While Reset_n=0 the block SHALL hold: state=IDLE, SRAM_CE_N=1, SRAM_WE_N=1, SRAM_ADDR=0, Data=Z, Wr_done=0, Busy=0, Wr_ready=0, and all queued requests discarded.
REQ-029 Reset asserted mid-write SHALL abort it immediately with no Wr_done.
REQ-030 Wr_ready SHALL rise no earlier than the first rising edge after Reset_n deasserts.

Configuration
REQ-031 With macro SRAM_WR_BUF_EN defined, requests SHALL pass through a 4-entry FIFO, and Wr_ready SHALL equal "FIFO not full", independent of FSM state and Rd_busy.
REQ-032 With SRAM_WR_BUF_EN defined, write throughput SHALL reach 1 write per PULSE_CYC+2 cycles via the HOLD->SETUP transition.
REQ-033 With SRAM_WR_BUF_EN defined, a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-034 With SRAM_WR_BUF_EN undefined, a single-entry register SHALL be used, Wr_ready SHALL be (state==IDLE && !Rd_busy), and throughput SHALL be 1 write per PULSE_CYC+3 cycles.

Structure
REQ-035 Package sram_pkg SHALL hold the state enum typedef (IDLE, SETUP, PULSE, HOLD) and default width constants SRAM_DW=16 and SRAM_AW=20.
REQ-036 Sub-module sram_wr_fifo SHALL be a parameterised synchronous FIFO (width A+N, depth 4) and SHALL be instantiated only under SRAM_WR_BUF_EN.

Verification
REQ-037 Reset then single write addr 0x00012, data 0xBEEF, PULSE_CYC=2 -> SETUP at cycle 1, WE_N low in cycles 2-3, Wr_done at cycle 4, Data=0xBEEF in cycles 1-4, Z after.
REQ-038 Rd_busy=1 held for 5 cycles with a pending request -> CE_N stays 1 and Data stays Z until Rd_busy falls; SETUP on the next cycle.
REQ-039 With buffer: 5 back-to-back requests -> Wr_ready drops after 4 queued; 5 Wr_done pulses spaced 4 cycles apart; addresses in order.
REQ-040 Without buffer: 2 back-to-back requests -> second accepted only in IDLE; Wr_done pulses 5 cycles apart.
REQ-041 Reset_n pulled low during the second PULSE cycle -> WE_N=1, CE_N=1 and Data=Z asynchronously; no Wr_done; FIFO empty after release.
REQ-042 Rd_busy raised during PULSE -> the write completes unchanged with Wr_done on schedule.
